// File: rtl/hb_pkg.sv
// Shared constants for the 2x halfband interpolator: widths, 0s18 coefficients, product slicing.
// Optional macro HBI_ROUND_EN selects round-half-up slicing; the default build truncates (floor).
package hb_pkg;
    localparam int WIDTH  = 18;
    localparam int NTAPS  = 8;
    localparam int NPRE   = NTAPS / 2;
    localparam int PWIDTH = 2 * WIDTH;

    localparam logic signed [WIDTH-1:0] HB_C0  = -18'sd20;
    localparam logic signed [WIDTH-1:0] HB_C1  = 18'sd197;
    localparam logic signed [WIDTH-1:0] HB_C2  = -18'sd981;
    localparam logic signed [WIDTH-1:0] HB_C3  = 18'sd4900;
    localparam logic signed [WIDTH-1:0] HB_CTR = 18'sd8192;

    localparam int PROD_MSB = 34;
    localparam int PROD_LSB = 17;
    localparam logic signed [PWIDTH-1:0] RND_K = 36'sd65536;

    function automatic logic signed [WIDTH-1:0] hb_coef(input int idx);
        case (idx)
            0:       return HB_C0;
            1:       return HB_C1;
            2:       return HB_C2;
            default: return HB_C3;
        endcase
    endfunction

    // Product slice back to 18 bits; the only arithmetic that differs between builds.
    function automatic logic signed [WIDTH-1:0] prod_slice(input logic signed [PWIDTH-1:0] m);
        logic [PWIDTH-1:0] r;
`ifdef HBI_ROUND_EN
        r = m + RND_K;
`else
        r = m;
`endif
        return r[PROD_MSB:PROD_LSB];
    endfunction
endpackage

// File: rtl/hb_side_mac.sv
// Side-tap phase of the halfband interpolator: symmetric pre-add, multiply, two-level sum tree.
// Three registered stages from the delay line to s3; no strobes are needed because the line is static between shifts.
module hb_side_mac
    import hb_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NTAPS*WIDTH-1:0] taps,
    output logic [WIDTH-1:0]       s3
);
    logic signed [WIDTH-1:0]  p  [NPRE];
    logic signed [PWIDTH-1:0] m  [NPRE];
    logic signed [WIDTH-1:0]  s2 [NPRE/2];

    always_comb begin
        for (int i = 0; i < NPRE; i++) begin
            m[i] = PWIDTH'(p[i]) * PWIDTH'(hb_coef(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPRE; i++) p[i] <= '0;
            for (int j = 0; j < NPRE/2; j++) s2[j] <= '0;
            s3 <= '0;
        end else begin
            for (int i = 0; i < NPRE; i++) begin
                p[i] <= $signed(taps[i*WIDTH +: WIDTH]) + $signed(taps[(NTAPS-1-i)*WIDTH +: WIDTH]);
            end
            for (int j = 0; j < NPRE/2; j++) begin
                s2[j] <= prod_slice(m[2*j]) + prod_slice(m[2*j+1]);
            end
            s3 <= s2[0] + s2[1];
        end
    end
endmodule

// File: rtl/halfband_interp_2x.sv
// 2x polyphase halfband interpolator: on-grid outputs from the side-tap MAC, mid outputs from the centre tap.
// Build option HBI_ROUND_EN (see hb_pkg) switches product slicing from truncation to round-half-up.
module halfband_interp_2x
    import hb_pkg::*;
(
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        sam_clk_en,
    input  logic        sys_clk2_en,
    input  logic [17:0] x_in,
    output logic [17:0] y,
    output logic        y_valid,
    output logic        phase
);
    logic signed [WIDTH-1:0]  x [NTAPS];
    logic [NTAPS*WIDTH-1:0]   taps;
    logic [WIDTH-1:0]         s3;
    logic signed [WIDTH-1:0]  cs;
    logic signed [PWIDTH-1:0] cm;

    always_comb begin
        taps = '0;
        for (int i = 0; i < NTAPS; i++) taps[i*WIDTH +: WIDTH] = x[i];
    end

    assign cm = PWIDTH'(x[NTAPS/2]) * PWIDTH'(HB_CTR);

    hb_side_mac u_side_mac (
        .clk   (sys_clk),
        .reset (reset),
        .taps  (taps),
        .s3    (s3)
    );

    // Samples enter halved (2s16) so the pre-adds cannot overflow; the output shift restores the gain.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) x[i] <= '0;
            cs      <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            phase   <= 1'b0;
        end else begin
            if (sam_clk_en) begin
                x[0] <= {x_in[17], x_in[17:1]};
                for (int i = 1; i < NTAPS; i++) x[i] <= x[i-1];
            end
            cs      <= prod_slice(cm);
            y_valid <= sys_clk2_en;
            if (sys_clk2_en) begin
                if (sam_clk_en) begin
                    y     <= s3 <<< 1;
                    phase <= 1'b0;
                end else begin
                    y     <= cs <<< 1;
                    phase <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_halfband_interp_2x.sv
// Directed bench for halfband_interp_2x: idle, impulse, DC step, mid-stream reset, minimum strobe spacing.
`timescale 1ns/1ps
module tb_halfband_interp_2x;
    logic        sys_clk = 1'b0;
    logic        reset = 1'b1;
    logic        sam_clk_en = 1'b0;
    logic        sys_clk2_en = 1'b0;
    logic [17:0] x_in = '0;
    logic [17:0] y;
    logic        y_valid;
    logic        phase;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [18:0] exp_q[$];
    logic [18:0] obs_q[$];
    int          obs_t[$];

`ifdef HBI_ROUND_EN
    localparam int IMP_C2 = -490;
    localparam int DC_ON  = 4098;
`else
    localparam int IMP_C2 = -492;
    localparam int DC_ON  = 4094;
`endif

    int imp_tab[20] = '{0, 0, -10, 0, 98, 0, IMP_C2, 0, 2450, 4096,
                        2450, 0, IMP_C2, 0, 98, 0, -10, 0, 0, 0};

    halfband_interp_2x dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .sam_clk_en  (sam_clk_en),
        .sys_clk2_en (sys_clk2_en),
        .x_in        (x_in),
        .y           (y),
        .y_valid     (y_valid),
        .phase       (phase)
    );

    // Clock and cycle stamp
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Monitor: capture {phase, y} on every valid pulse, away from the active edge
    always @(negedge sys_clk) begin
        if (y_valid) begin
            obs_q.push_back({phase, y});
            obs_t.push_back(cyc);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] ev(input logic ph, input int v);
        logic [31:0] t;
        t = v;
        return {ph, t[17:0]};
    endfunction

    // One input period: on-grid strobe with capture, then a mid strobe half periods later
    task automatic frame(input logic [17:0] v, input int half);
        @(negedge sys_clk);
        sam_clk_en = 1'b1; sys_clk2_en = 1'b1; x_in = v;
        @(negedge sys_clk);
        sam_clk_en = 1'b0; sys_clk2_en = 1'b0; x_in = '0;
        repeat (half - 1) @(negedge sys_clk);
        sys_clk2_en = 1'b1;
        @(negedge sys_clk);
        sys_clk2_en = 1'b0;
        repeat (half - 2) @(negedge sys_clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge sys_clk);
        reset = 1'b1; sam_clk_en = 1'b0; sys_clk2_en = 1'b0; x_in = '0;
        @(negedge sys_clk);
        reset = 1'b0;
        check($sformatf("%s_rst_y", tag), y, 0);
        check($sformatf("%s_rst_valid", tag), y_valid, 0);
        check($sformatf("%s_rst_phase", tag), phase, 0);
        obs_q.delete();
        obs_t.delete();
    endtask

    // Scoreboard: compare observed outputs (after skipping fill outputs) against exp_q
    task automatic compare_outputs(input string tag, input int skip);
        logic [18:0] got;
        repeat (3) @(negedge sys_clk);
        check($sformatf("%s_count", tag), obs_q.size(), skip + exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i + skip < obs_q.size()) got = obs_q[i + skip];
            else got = 'x;
            check($sformatf("%s[%0d]", tag, i), got, exp_q[i]);
        end
        exp_q.delete();
        obs_q.delete();
        obs_t.delete();
    endtask

    task automatic run_impulse(input string tag, input int half);
        do_reset(tag);
        frame(18'd65536, half);
        for (int k = 0; k < 9; k++) frame(18'd0, half);
        for (int i = 0; i < 20; i++) exp_q.push_back(ev(i[0], imp_tab[i]));
        compare_outputs(tag, 0);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);

        // Idle: zeros, alternating phase, valid every 4 cycles
        do_reset("idle");
        for (int k = 0; k < 4; k++) frame(18'd0, 4);
        for (int i = 1; i < obs_t.size(); i++) check($sformatf("idle_gap[%0d]", i), obs_t[i] - obs_t[i-1], 4);
        for (int i = 0; i < 8; i++) exp_q.push_back(ev(i[0], 0));
        compare_outputs("idle", 0);

        // Impulse with relaxed strobe spacing
        run_impulse("impulse", 8);

        // DC step: check only after the delay line has filled
        do_reset("dc");
        for (int k = 0; k < 12; k++) frame(18'd65536, 4);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ev(1'b0, DC_ON));
            exp_q.push_back(ev(1'b1, 4096));
        end
        compare_outputs("dc", 16);

        // Reset during the impulse tail clears everything
        do_reset("mid");
        frame(18'd65536, 4);
        for (int k = 0; k < 5; k++) frame(18'd0, 4);
        do_reset("mid_hit");
        for (int k = 0; k < 10; k++) frame(18'd0, 4);
        for (int i = 0; i < 20; i++) exp_q.push_back(ev(i[0], 0));
        compare_outputs("mid_after", 0);

        // Minimum strobe spacing
        run_impulse("impulse_min", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
